// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store sequencer, sub-word stores by read-modify-write.
// Define LSU_ALIGN_CHECK_EN to flag misaligned/reserved accesses instead of masking low address bits.
module load_store_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              misaligned,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_merged, r_rdata;
  logic [1:0] r_size, w_off;
  logic r_we, r_sext, r_mis, w_mis, w_byte, w_half;
  logic [DATA_W-1:0] w_mask, w_lane, w_load, w_merge;
`ifdef LSU_ALIGN_CHECK_EN
  assign w_mis = (size == 2'b11) | (size == 2'b10 & |addr[1:0]) | (size == 2'b01 & addr[0]);
`else
  assign w_mis = 1'b0;
`endif
  // Reserved size only reaches the datapath when unchecked, where it acts as a word.
  assign w_byte = r_size == 2'b00;
  assign w_half = r_size == 2'b01;
  assign w_off = w_byte ? r_addr[1:0] : w_half ? {r_addr[1], 1'b0} : 2'b00;
  assign w_mask = w_byte ? 32'h0000_00FF : w_half ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  assign w_lane = (mem_rdata >> {w_off, 3'b000}) & w_mask;
  assign w_load = w_byte ? {{24{r_sext & w_lane[7]}}, w_lane[7:0]} :
                  w_half ? {{16{r_sext & w_lane[15]}}, w_lane[15:0]} : w_lane;
  assign w_merge = (mem_rdata & ~(w_mask << {w_off, 3'b000})) | ((r_wdata & w_mask) << {w_off, 3'b000});
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = IDLE;
    w_next = r_state == IDLE  ? (req ? (w_mis ? DONE : (we & size[1]) ? WRITE : READ) : IDLE) :
             r_state == READ  ? (r_we ? WRITE : DONE) :
             r_state == WRITE ? DONE : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_size   <= 2'b00;
      r_sext   <= 1'b0;
      r_wdata  <= '0;
      r_mis    <= 1'b0;
      r_merged <= '0;
      r_rdata  <= '0;
    end else begin
      if (r_state == IDLE && req) begin
        r_addr   <= addr;
        r_we     <= we;
        r_size   <= size;
        r_sext   <= sign_ext;
        r_wdata  <= wdata;
        r_mis    <= w_mis;
        r_merged <= wdata;
      end
      if (r_state == READ) begin
        if (r_we) r_merged <= w_merge;
        else r_rdata <= w_load;
      end
    end
  end
  assign busy       = r_state != IDLE;
  assign done       = r_state == DONE;
  assign misaligned = done & r_mis;
  assign mem_read   = r_state == READ;
  assign mem_write  = r_state == WRITE;
  assign mem_addr   = {r_addr[ADDR_W-1:2], 2'b00};
  assign mem_wdata  = r_merged;
  assign rdata      = r_rdata;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized scoreboard bench with a byte-lane reference memory model.
module tb_load_store_unit;
  logic clk = 1'b0, reset = 1'b1, req = 1'b0, we = 1'b0, sign_ext = 1'b0;
  logic [1:0] size = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic busy, done, misaligned, mem_read, mem_write;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic [31:0] last = '0;
  int cyc = 0, checks = 0, errors = 0, done_cnt = 0;
  typedef struct {
    logic [31:0] rd;
    logic        mis;
    int          lat;
    int          t0;
    logic        rdq;
    logic        wrq;
    logic [31:0] wd;
  } exp_t;
  exp_t q[$];

  load_store_unit dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .misaligned(misaligned), .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
  assign mem_rdata = mem[mem_addr[7:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic srd, swr;
    exp_t e;
    srd = 1'b0;
    swr = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        srd = 1'b0;
        swr = 1'b0;
      end else begin
        if (mem_read) srd = 1'b1;
        if (mem_write) begin
          swr = 1'b1;
          if (q.size() == 0) chk("write_without_access", 32'(mem_write), 32'd0);
          else chk("mem_wdata", mem_wdata, q[0].wd);
        end
        if (done) begin
          done_cnt++;
          if (q.size() == 0) chk("done_without_access", 32'(done), 32'd0);
          else begin
            e = q.pop_front();
            chk("latency", 32'(cyc - e.t0), 32'(e.lat));
            chk("misaligned", 32'(misaligned), 32'(e.mis));
            chk("rdata", rdata, e.rd);
            chk("mem_read_seen", 32'(srd), 32'(e.rdq));
            chk("mem_write_seen", 32'(swr), 32'(e.wrq));
            srd = 1'b0;
            swr = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    logic [1:0] s;
    logic m;
    int off, nb, i;
    longint unsigned mask, v;
    wait_idle();
    s = sz;
    m = 1'b0;
    off = int'(a[1:0]);
`ifdef LSU_ALIGN_CHECK_EN
    m = (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0);
`else
    if (s == 2'd3) s = 2'd2;
`endif
    nb = s == 2'd0 ? 1 : s == 2'd1 ? 2 : 4;
    off = off - off % nb;
    i = int'(a[7:2]);
    mask = (64'd1 << (8 * nb)) - 64'd1;
    e.mis = m;
    e.t0 = cyc;
    e.rdq = !m && !(w && nb == 4);
    e.wrq = w && !m;
    e.wd = '0;
    e.lat = m ? 1 : (w && nb < 4) ? 3 : 2;
    if (!m && !w) begin
      v = (64'(ref_mem[i]) >> (8 * off)) & mask;
      if (sx && v[8 * nb - 1]) v = v | ~mask;
      last = v[31:0];
    end
    if (!m && w) begin
      v = (64'(ref_mem[i]) & ~(mask << (8 * off))) | ((64'(d) & mask) << (8 * off));
      ref_mem[i] = v[31:0];
      e.wd = v[31:0];
    end
    e.rd = last;
    we = w; size = sz; sign_ext = sx; addr = a; wdata = d; req = 1'b1;
    q.push_back(e);
    @(negedge clk);
    req = 1'b0;
  endtask

  initial begin
    int n;
    int dc;
    fork monitor(); join_none
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_misaligned", 32'(misaligned), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    for (int i = 0; i < 64; i++) access(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom);
    access(1'b1, 2'd2, 1'b0, 32'h50, 32'h5);
    access(1'b0, 2'd2, 1'b0, 32'h50, 32'h0);
    wait_idle(); chk("word_load", rdata, 32'h0000_0005);
    access(1'b1, 2'd2, 1'b0, 32'h54, 32'h1122_3344);
    access(1'b1, 2'd0, 1'b0, 32'h55, 32'h0000_00AB);
    access(1'b0, 2'd2, 1'b0, 32'h54, 32'h0);
    wait_idle(); chk("byte_store", rdata, 32'h1122_AB44);
    access(1'b1, 2'd2, 1'b0, 32'h54, 32'h80FF_7F01);
    access(1'b0, 2'd0, 1'b1, 32'h57, 32'h0);
    wait_idle(); chk("lb", rdata, 32'hFFFF_FF80);
    access(1'b0, 2'd0, 1'b0, 32'h57, 32'h0);
    wait_idle(); chk("lbu", rdata, 32'h0000_0080);
    access(1'b0, 2'd1, 1'b1, 32'h56, 32'h0);
    wait_idle(); chk("lh", rdata, 32'hFFFF_80FF);
    access(1'b0, 2'd1, 1'b0, 32'h54, 32'h0);
    wait_idle(); chk("lhu", rdata, 32'h0000_7F01);
    access(1'b0, 2'd2, 1'b0, 32'h52, 32'h0);
    wait_idle();
`ifdef LSU_ALIGN_CHECK_EN
    chk("misaligned_load", rdata, 32'h0000_7F01);
`else
    chk("unaligned_load", rdata, 32'h0000_0005);
`endif
    wait_idle();
    we = 1'b1; size = 2'd1; sign_ext = 1'b0; addr = 32'h58; wdata = 32'h0000_BEEF; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    chk("abort_in_read", 32'(mem_read), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_mem_write", 32'(mem_write), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    last = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_mem_word", mem[22], ref_mem[22]);
    dc = done_cnt;
    access(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    we = 1'b1; size = 2'd2; addr = 32'h44; wdata = 32'hDEAD_BEEF; req = 1'b1;
    repeat (2) @(negedge clk);
    req = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    chk("single_done", 32'(done_cnt - dc), 32'd1);
    repeat (60) begin
`ifdef LSU_ALIGN_CHECK_EN
      access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 255)), $urandom);
`else
      access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 255)), $urandom);
`endif
    end
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(q.size()), 32'd0);
    for (int i = 0; i < 64; i++) chk("mem_final", mem[i], ref_mem[i]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
